// File: rtl/accfp16.sv
`default_nettype none
// ============================================================================
// accfp16 : packet accumulator for FP16 products, bias-seeded, truncating add
// Revision : 1.0
// ============================================================================
module accfp16 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic [15:0]      bias_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready
);

  typedef enum logic [0:0] {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [15:0]      C_QNAN    = 16'h7E00;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  // Mantissas carry 3 extra bits (guard, round, sticky) below the LSB.
  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    logic        x_nan, y_nan, x_inf, y_inf, swap, sticky;
    logic [15:0] a, b, r;
    logic [4:0]  ea, eb, d;
    logic [13:0] ma, mb, mb_sh, lost_mask, mbs, sn;
    logic [14:0] s;
    logic [5:0]  er;
    logic [3:0]  lz, sh;
    x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
    swap = 1'b0; sticky = 1'b0; a = x; b = y; r = 16'h0000;
    ea = 5'd1; eb = 5'd1; d = 5'd0; ma = '0; mb = '0; mb_sh = '0;
    lost_mask = '0; mbs = '0; sn = '0; s = '0; er = '0; lz = '0; sh = '0;
    if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) begin
      r = C_QNAN;
    end else if (x_inf) begin
      r = x;
    end else if (y_inf) begin
      r = y;
    end else begin
      swap      = (y[14:0] > x[14:0]);
      a         = swap ? y : x;
      b         = swap ? x : y;
      ea        = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      eb        = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      d         = ea - eb;
      ma        = {(a[14:10] != 5'd0), a[9:0], 3'b000};
      mb        = {(b[14:10] != 5'd0), b[9:0], 3'b000};
      mb_sh     = mb >> d;
      lost_mask = ~(14'h3FFF << d);
      sticky    = |(mb & lost_mask);
      mbs       = {mb_sh[13:1], mb_sh[0] | sticky};
      if (a[15] == b[15]) s = {1'b0, ma} + {1'b0, mbs};
      else                s = {1'b0, ma} - {1'b0, mbs};
      er = {1'b0, ea};
      if (s[14]) begin
        sn = s[14:1];
        er = er + 6'd1;
      end else begin
        lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
          if (s[i]) lz = 4'(13 - i);
        end
        // Normalise no further than exponent 1; anything left over is subnormal.
        if ({2'b00, lz} > (er - 6'd1)) sh = 4'(er - 6'd1);
        else                           sh = lz;
        sn = s[13:0] << sh;
        er = er - {2'b00, sh};
      end
      if (s == 15'd0)          r = {a[15] & b[15], 15'h0000};
      else if (er > 6'd30)     r = {a[15], 15'h7C00};
      else                     r = {a[15], (sn[13] ? er[4:0] : 5'd0), sn[12:3]};
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             accept;
  logic [15:0]      sum;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready  = (state_q == ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    sum         = fadd(first_q ? bias_in : acc_q, in_data);
    cnt_next    = first_q ? CNT_W'(1)
                : ((cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d   = sum;
          cnt_d   = cnt_next;
          first_d = 1'b0;
          if (in_last) begin
            out_data_d  = sum;
            out_count_d = cnt_next;
            out_valid_d = 1'b1;
            first_d     = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      first_q     <= 1'b1;
      acc_q       <= 16'h0000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accfp16.sv
`default_nettype none
// ============================================================================
// tb_accfp16 : self-checking bench for accfp16 against a real-arithmetic model
// Revision : 1.0
// ============================================================================
module tb_accfp16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = 16'h0000, bias_in = 16'h0000;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [15:0] out_data, out_data2;
  logic [7:0]  out_count;
  logic [1:0]  out_count2;
  int          vectors = 0, miscompares = 0;
  logic [15:0] pkt [0:15];

  accfp16 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .bias_in(bias_in), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_count(out_count), .out_ready(out_ready));

  accfp16 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .bias_in(bias_in), .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_count(out_count2), .out_ready(out_ready));

  always #5 clk = ~clk;

  // Value in units of 2^-24 (the smallest subnormal), so every finite FP16 is an integer.
  function automatic longint to_int(input logic [15:0] v);
    longint mag;
    if (v[14:10] == 5'd0) mag = longint'(v[9:0]);
    else                  mag = longint'({1'b1, v[9:0]}) << (v[14:10] - 1);
    return v[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    bit xn, yn, xi, yi, sg;
    longint sm, m;
    int p, e;
    logic [15:0] r;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    if (xn || yn) return 16'h7E00;
    if (xi && yi) return (x[15] == y[15]) ? x : 16'h7E00;
    if (xi) return x;
    if (yi) return y;
    sm = to_int(x) + to_int(y);
    if (sm == 0) return (x[15] && y[15]) ? 16'h8000 : 16'h0000;
    sg = (sm < 0);
    m  = sg ? -sm : sm;
    p  = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    if (p < 10) return {sg, 5'd0, m[9:0]};
    e = p - 9;
    if (e > 30) return {sg, 15'h7C00};
    m = m >> (p - 10);
    r = {sg, e[4:0], m[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] ref_pkt(input logic [15:0] bias, input int n);
    logic [15:0] a;
    a = bias;
    for (int i = 0; i < n; i++) a = ref_add(a, pkt[i]);
    return a;
  endfunction

  function automatic logic [15:0] rand_fp();
    int k;
    logic [15:0] v;
    k = $urandom_range(0, 15);
    v = 16'($urandom);
    if (k == 0)      begin v[14:10] = 5'h1F; if ($urandom_range(0, 1) == 0) v[9:0] = 10'd0; end
    else if (k < 3)  v[14:10] = 5'd0;
    else if (k == 3) v[14:10] = 5'($urandom_range(25, 30));
    else             v[14:10] = 5'($urandom_range(1, 18));
    return v;
  endfunction

  // Drives n beats from pkt[], then samples the outputs one cycle after the last beat.
  task automatic drive_pkt(input logic [15:0] bias, input int n, input bit release_out,
                           output logic ov, output logic [15:0] d, output logic [7:0] c,
                           output logic [1:0] c2, output logic [15:0] d2);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == n - 1);
      bias_in  = (i == 0) ? bias : 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    in_data  = 16'($urandom); bias_in = 16'($urandom);
    ov = out_valid; d = out_data; c = out_count; c2 = out_count2; d2 = out_data2;
    if (release_out) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 5;
    if (in_ready !== 1'b0)    begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0)   begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_data !== 16'h0)   begin miscompares++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    if (out_count !== 8'd0)   begin miscompares++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
    if (out_valid2 !== 1'b0)  begin miscompares++; $display("FAIL rst_out_valid2: got %b want 0", out_valid2); end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic ov; logic [15:0] d, d2; logic [7:0] c; logic [1:0] c2;
    logic [15:0] tb_b [0:8], tb_x [0:8], tb_e [0:8];
    pkt[0] = 16'h3C00; pkt[1] = 16'h4000; pkt[2] = 16'h4200;
    drive_pkt(16'h0000, 3, 1'b1, ov, d, c, c2, d2);
    vectors += 3;
    if (ov !== 1'b1)     begin miscompares++; $display("FAIL sum3_valid: got %b want 1", ov); end
    if (d !== 16'h4600)  begin miscompares++; $display("FAIL sum3_data: got %h want 4600", d); end
    if (c !== 8'd3)      begin miscompares++; $display("FAIL sum3_count: got %0d want 3", c); end
    tb_b = '{16'h3C00, 16'h8000, 16'h0001, 16'h03FF, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h7C00};
    tb_x = '{16'hBC00, 16'h8000, 16'h0001, 16'h0001, 16'h1000, 16'h8C00, 16'h7BFF, 16'hFC00, 16'h3C00};
    tb_e = '{16'h0000, 16'h8000, 16'h0002, 16'h0400, 16'h3C00, 16'h3BFF, 16'h7C00, 16'h7E00, 16'h7C00};
    for (int k = 0; k < 9; k++) begin
      pkt[0] = tb_x[k];
      drive_pkt(tb_b[k], 1, 1'b1, ov, d, c, c2, d2);
      vectors += 2;
      if (d !== tb_e[k]) begin miscompares++; $display("FAIL dir_data %h+%h: got %h want %h", tb_b[k], tb_x[k], d, tb_e[k]); end
      if (c !== 8'd1)    begin miscompares++; $display("FAIL dir_count %0d: got %0d want 1", k, c); end
    end
  endtask

  task automatic test_random();
    logic ov; logic [15:0] d, d2, e; logic [7:0] c; logic [1:0] c2;
    int n;
    for (int p = 0; p < 60; p++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) pkt[i] = rand_fp();
      e = 16'($urandom);
      e = rand_fp();
      d = ref_pkt(e, n);
      drive_pkt(e, n, 1'b1, ov, e, c, c2, d2);
      vectors += 6;
      if (ov !== 1'b1)   begin miscompares++; $display("FAIL rnd_valid pkt %0d: got %b want 1", p, ov); end
      if (e !== d)       begin miscompares++; $display("FAIL rnd_data pkt %0d: got %h want %h", p, e, d); end
      if (d2 !== d)      begin miscompares++; $display("FAIL rnd_data2 pkt %0d: got %h want %h", p, d2, d); end
      if (c !== 8'(n))   begin miscompares++; $display("FAIL rnd_count pkt %0d: got %0d want %0d", p, c, n); end
      if (c2 !== 2'((n > 3) ? 3 : n)) begin miscompares++; $display("FAIL rnd_count2 pkt %0d: got %0d want %0d", p, c2, (n > 3) ? 3 : n); end
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++; $display("FAIL rnd_release pkt %0d: got valid=%b ready=%b want 0/1", p, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int n;
    for (int p = 0; p < 3; p++) begin
      n = p + 2;
      for (int i = 0; i < n; i++) pkt[i] = rand_fp();
      e = rand_fp();
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b1; in_data = pkt[i]; in_last = (i == n - 1);
        bias_in = (i == 0) ? e : 16'($urandom);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready pkt %0d beat %0d: got %b want 1", p, i, in_ready); end
        @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      vectors += 3;
      if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL b2b_hold_ready pkt %0d: got %b want 0", p, in_ready); end
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid pkt %0d: got %b want 1", p, out_valid); end
      if (out_data !== ref_pkt(e, n)) begin miscompares++; $display("FAIL b2b_data pkt %0d: got %h want %h", p, out_data, ref_pkt(e, n)); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic ov; logic [15:0] d, d2, b2; logic [7:0] c; logic [1:0] c2;
    out_ready = 1'b0;
    pkt[0] = 16'h4000; pkt[1] = 16'h3800;
    drive_pkt(16'h3C00, 2, 1'b0, ov, d, c, c2, d2);
    vectors += 2;
    if (ov !== 1'b1 || d !== 16'h4300) begin miscompares++; $display("FAIL bp_first: got valid=%b data=%h want 1/4300", ov, d); end
    if (c !== 8'd2) begin miscompares++; $display("FAIL bp_count: got %0d want 2", c); end
    b2 = rand_fp(); pkt[0] = rand_fp();
    in_valid = 1'b1; in_data = pkt[0]; in_last = 1'b1; bias_in = b2;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d || out_count !== c) begin
        miscompares++;
        $display("FAIL bp_stall cyc %0d: got ready=%b valid=%b data=%h cnt=%0d want 0/1/%h/%0d", i, in_ready, out_valid, out_data, out_count, d, c);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== d) begin
      miscompares++; $display("FAIL bp_release: got valid=%b ready=%b data=%h want 0/1/%h", out_valid, in_ready, out_data, d);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== ref_add(b2, pkt[0]) || out_count !== 8'd1) begin
      miscompares++;
      $display("FAIL bp_next: got valid=%b data=%h cnt=%0d want 1/%h/1", out_valid, out_data, out_count, ref_add(b2, pkt[0]));
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic ov; logic [15:0] d, d2; logic [7:0] c; logic [1:0] c2;
    for (int i = 0; i < 6; i++) pkt[i] = 16'h3C00;
    drive_pkt(16'h0000, 6, 1'b1, ov, d, c, c2, d2);
    vectors += 3;
    if (c !== 8'd6)     begin miscompares++; $display("FAIL sat_count8: got %0d want 6", c); end
    if (c2 !== 2'd3)    begin miscompares++; $display("FAIL sat_count2: got %0d want 3", c2); end
    if (d !== 16'h4600) begin miscompares++; $display("FAIL sat_data: got %h want 4600", d); end
  endtask

  task automatic test_midpacket_reset();
    logic ov; logic [15:0] d, d2, b; logic [7:0] c; logic [1:0] c2;
    for (int s = 0; s < 2; s++) begin
      pkt[0] = 16'h3C00;
      out_ready = (s == 0);
      drive_pkt(16'h3C00, 1, 1'b0, ov, d, c, c2, d2);
      if (s == 0) begin
        @(negedge clk);
        pkt[0] = 16'h4400; pkt[1] = 16'h4400;
        in_valid = 1'b1; in_data = pkt[0]; in_last = 1'b0; bias_in = 16'h4000;
        @(negedge clk);
        in_data = pkt[1];
        @(negedge clk);
        in_valid = 1'b0;
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 8'd0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_rst %0d: got valid=%b data=%h cnt=%0d ready=%b want 0/0000/0/0", s, out_valid, out_data, out_count, in_ready);
      end
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_quiet %0d cyc %0d: got %b want 0", s, i, out_valid); end
        @(negedge clk);
      end
      b = rand_fp(); pkt[0] = rand_fp();
      drive_pkt(b, 1, 1'b1, ov, d, c, c2, d2);
      vectors++;
      if (d !== ref_add(b, pkt[0]) || c !== 8'd1) begin
        miscompares++; $display("FAIL mid_rst_next %0d: got %h/%0d want %h/1", s, d, c, ref_add(b, pkt[0]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_midpacket_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
